// File: rtl/jtframe_prog_seq.sv
// jtframe_prog_seq: turns the ioctl ROM-download byte stream into SDRAM
// byte writes. Each byte is decoded to a bank/word/lane, queued in a small
// FIFO and written through the prog_* request/ack/ready handshake.
//
// Handshake: prog_we rises with all prog_* fields registered and stable; it
// stays high until the edge where prog_ack is sampled, then drops. The FIFO
// head is popped only on prog_rdy, so no new request starts before the
// current write has completed.
module jtframe_prog_seq #(
   parameter int          SDRAMW    = 23,
   parameter logic [24:0] BA1_START = 25'h040000,
   parameter logic [24:0] BA2_START = 25'h080000,
   parameter logic [24:0] BA3_START = 25'h0C0000,
   parameter int          AW        = 2
) (
   input  logic              clk_rom,
   input  logic              rst_n,
   input  logic              downloading,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic              ioctl_wr,
   output logic [SDRAMW-1:0] prog_addr,
   output logic [15:0]       prog_data,
   output logic [1:0]        prog_mask,
   output logic [1:0]        prog_ba,
   output logic              prog_we,
   output logic              prog_rd,
   input  logic              prog_ack,
   input  logic              prog_rdy,
   output logic              dwnld_busy,
   output logic              overflow
);

   localparam int EW    = 2 + SDRAMW + 2 + 8;
   localparam int DEPTH = 1 << AW;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

   state_t            state, state_nx;
   logic              load, we_clr, pop;
   logic              push_req, push, drop;
   logic              empty, full;
   logic              dl_d;
   logic [AW:0]       wr_ptr, rd_ptr;
   logic [EW-1:0]     mem [0:DEPTH-1];
   logic [EW-1:0]     head, entry;
   logic [24:0]       off;
   logic [1:0]        dec_ba;
   logic [1:0]        dec_mask;
   logic [SDRAMW-1:0] dec_addr;

   // Bank decode: highest matching bank start wins, offset is relative to it
   always_comb begin
      dec_ba = 2'd0;
      off    = ioctl_addr;
      if (ioctl_addr >= BA3_START) begin
         dec_ba = 2'd3;
         off    = ioctl_addr - BA3_START;
      end else if (ioctl_addr >= BA2_START) begin
         dec_ba = 2'd2;
         off    = ioctl_addr - BA2_START;
      end else if (ioctl_addr >= BA1_START) begin
         dec_ba = 2'd1;
         off    = ioctl_addr - BA1_START;
      end
      // Offset bits above the word address are dropped: writes wrap in the bank
      dec_addr = off[SDRAMW:1];
      dec_mask = off[0] ? 2'b01 : 2'b10;
   end

   assign entry    = {dec_ba, dec_addr, dec_mask, ioctl_dout};
   assign head     = mem[rd_ptr[AW-1:0]];
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push_req = ioctl_wr & downloading;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts
   assign push     = push_req & (~full | pop);
   assign drop     = push_req & full & ~pop;

   // FIFO storage: data only, validity comes from the pointers
   always_ff @(posedge clk_rom) begin
      if (push) mem[wr_ptr[AW-1:0]] <= entry;
   end

   // FIFO pointers
   always_ff @(posedge clk_rom or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // FSM state register
   always_ff @(posedge clk_rom or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // FSM next state: start a write from the head, pop it only on prog_rdy
   always_comb begin
      state_nx = state;
      load     = 1'b0;
      we_clr   = 1'b0;
      pop      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!empty) begin
               load     = 1'b1;
               state_nx = ST_REQ;
            end
         end
         ST_REQ: begin
            if (prog_ack) begin
               we_clr = 1'b1;
               if (prog_rdy) begin
                  pop      = 1'b1;
                  state_nx = ST_IDLE;
               end else begin
                  state_nx = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (prog_rdy) begin
               pop      = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // prog_* output registers: loaded once per write, held until the next load
   always_ff @(posedge clk_rom or negedge rst_n) begin
      if (!rst_n) begin
         prog_addr <= '0;
         prog_data <= 16'd0;
         prog_mask <= 2'b11;
         prog_ba   <= 2'd0;
         prog_we   <= 1'b0;
      end else if (load) begin
         prog_ba   <= head[EW-1 -: 2];
         prog_addr <= head[EW-3 -: SDRAMW];
         prog_mask <= head[9:8];
         prog_data <= {head[7:0], head[7:0]};
         prog_we   <= 1'b1;
      end else if (we_clr) begin
         prog_we   <= 1'b0;
      end
   end

   // Sticky overflow, cleared when a new download starts
   always_ff @(posedge clk_rom or negedge rst_n) begin
      if (!rst_n) begin
         dl_d     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         dl_d <= downloading;
         if (drop)                     overflow <= 1'b1;
         else if (downloading && !dl_d) overflow <= 1'b0;
      end
   end

   assign prog_rd    = 1'b0;
   assign dwnld_busy = downloading | ~empty | (state != ST_IDLE);

endmodule

// File: tb/tb_jtframe_prog_seq.sv
// Bench for jtframe_prog_seq. Stimulus pushes the hand-computed SDRAM write
// it expects into exp_q; an SDRAM model process serves every request,
// pops the expected entry and compares, and checks the handshake rules.
module tb_jtframe_prog_seq;

   localparam int SDRAMW = 23;

   logic              clk_rom = 1'b0;
   logic              rst_n;
   logic              downloading;
   logic [24:0]       ioctl_addr;
   logic [7:0]        ioctl_dout;
   logic              ioctl_wr;
   logic [SDRAMW-1:0] prog_addr;
   logic [15:0]       prog_data;
   logic [1:0]        prog_mask;
   logic [1:0]        prog_ba;
   logic              prog_we;
   logic              prog_rd;
   logic              prog_ack;
   logic              prog_rdy;
   logic              dwnld_busy;
   logic              overflow;

   int          checks   = 0;
   int          failures = 0;
   logic [42:0] exp_q[$];

   // SDRAM model controls
   int ack_dly  = 1;
   int rdy_dly  = 1;
   bit ack_hold = 1'b0;
   bit rdy_hold = 1'b0;
   bit abort    = 1'b0;
   int req_cnt  = 0;
   int done_cnt = 0;

   jtframe_prog_seq dut (
      .clk_rom     (clk_rom),
      .rst_n       (rst_n),
      .downloading (downloading),
      .ioctl_addr  (ioctl_addr),
      .ioctl_dout  (ioctl_dout),
      .ioctl_wr    (ioctl_wr),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .prog_mask   (prog_mask),
      .prog_ba     (prog_ba),
      .prog_we     (prog_we),
      .prog_rd     (prog_rd),
      .prog_ack    (prog_ack),
      .prog_rdy    (prog_rdy),
      .dwnld_busy  (dwnld_busy),
      .overflow    (overflow)
   );

   // Clock and watchdog
   always #5 clk_rom = ~clk_rom;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [42:0] ent(input logic [1:0] ba, input logic [22:0] a,
                                       input logic [1:0] m, input logic [15:0] d);
      return {ba, a, m, d};
   endfunction

   // Driver: one ioctl_wr strobe
   task automatic send(input logic [24:0] a, input logic [7:0] d, input logic [42:0] e);
      @(negedge clk_rom);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      exp_q.push_back(e);
      @(negedge clk_rom);
      ioctl_wr   = 1'b0;
   endtask

   // Wait (bounded) until n writes have completed
   task automatic wait_done(input int n, input bit chk_busy, input string tag);
      int cyc = 0;
      while (done_cnt < n && cyc < 300) begin
         @(negedge clk_rom);
         #1;
         cyc++;
         if (chk_busy && done_cnt < n) check({tag, "_busy_hold"}, dwnld_busy, 1);
      end
      check({tag, "_done"}, done_cnt, n);
      if (chk_busy) check({tag, "_busy_low"}, dwnld_busy, 0);
   endtask

   // SDRAM model: serve one request, comparing it against the scoreboard
   task automatic serve();
      logic [42:0] snap;
      logic [42:0] e;
      bit          bad;
      int          i;
      snap = {prog_ba, prog_addr, prog_mask, prog_data};
      req_cnt++;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_write actual=%0h required=none", snap);
      end else begin
         e = exp_q.pop_front();
         check("write_entry", snap, e);
      end
      bad = 1'b0;
      i   = 0;
      while (ack_hold || i < ack_dly) begin
         @(negedge clk_rom);
         if (abort) return;
         if (!prog_we || {prog_ba, prog_addr, prog_mask, prog_data} !== snap) bad = 1'b1;
         i++;
      end
      check("req_stable", bad, 0);
      prog_ack = 1'b1;
      @(negedge clk_rom);
      prog_ack = 1'b0;
      if (abort) return;
      check("we_drop_after_ack", prog_we, 0);
      bad = 1'b0;
      i   = 0;
      while (rdy_hold || i < rdy_dly) begin
         @(negedge clk_rom);
         if (abort) return;
         if (prog_we) bad = 1'b1;
         i++;
      end
      check("no_req_before_rdy", bad, 0);
      prog_rdy = 1'b1;
      @(negedge clk_rom);
      prog_rdy = 1'b0;
      done_cnt++;
   endtask

   // Monitor process
   initial begin
      prog_ack = 1'b0;
      prog_rdy = 1'b0;
      forever begin
         @(negedge clk_rom);
         if (rst_n === 1'b1 && prog_we === 1'b1 && !abort) serve();
         abort = 1'b0;
      end
   end

   // Directed stimulus
   initial begin
      int base;
      int base_req;
      rst_n       = 1'b0;
      downloading = 1'b0;
      ioctl_addr  = '0;
      ioctl_dout  = '0;
      ioctl_wr    = 1'b0;
      #23;
      rst_n = 1'b1;
      @(negedge clk_rom);
      check("rst_prog_we",   prog_we,    0);
      check("rst_prog_rd",   prog_rd,    0);
      check("rst_prog_addr", prog_addr,  0);
      check("rst_prog_data", prog_data,  0);
      check("rst_prog_mask", prog_mask,  2'b11);
      check("rst_prog_ba",   prog_ba,    0);
      check("rst_busy",      dwnld_busy, 0);
      check("rst_overflow",  overflow,   0);
      downloading = 1'b1;
      #1;
      check("busy_follows_dl", dwnld_busy, 1);

      // Single byte with late ack and late rdy
      ack_dly = 3;
      rdy_dly = 4;
      @(negedge clk_rom);
      ioctl_addr = 25'h000003;
      ioctl_dout = 8'hA5;
      ioctl_wr   = 1'b1;
      exp_q.push_back(ent(2'd0, 23'h1, 2'b01, 16'hA5A5));
      @(negedge clk_rom);
      ioctl_wr = 1'b0;
      check("lat_we_low_k", prog_we, 0);
      @(negedge clk_rom);
      check("lat_we_high_k1", prog_we, 1);
      downloading = 1'b0;
      wait_done(1, 1'b1, "single");

      // Bank decode
      ack_dly     = 1;
      rdy_dly     = 1;
      downloading = 1'b1;
      send(25'h03FFFF, 8'h11, ent(2'd0, 23'h1FFFF, 2'b01, 16'h1111));
      send(25'h040000, 8'h22, ent(2'd1, 23'h0,     2'b10, 16'h2222));
      send(25'h080002, 8'h33, ent(2'd2, 23'h1,     2'b10, 16'h3333));
      send(25'h0C0005, 8'h44, ent(2'd3, 23'h2,     2'b01, 16'h4444));
      wait_done(5, 1'b0, "bank");

      // Overflow: rdy held off, six back-to-back strobes
      downloading = 1'b0;
      repeat (2) @(negedge clk_rom);
      downloading = 1'b1;
      repeat (2) @(negedge clk_rom);
      rdy_hold = 1'b1;
      base     = done_cnt;
      base_req = req_cnt;
      for (int i = 0; i < 6; i++) begin
         ioctl_addr = 25'h000100 + 25'(i);
         ioctl_dout = 8'h10 + 8'(i);
         ioctl_wr   = 1'b1;
         case (i)
            0: exp_q.push_back(ent(2'd0, 23'h80, 2'b10, 16'h1010));
            1: exp_q.push_back(ent(2'd0, 23'h80, 2'b01, 16'h1111));
            2: exp_q.push_back(ent(2'd0, 23'h81, 2'b10, 16'h1212));
            3: exp_q.push_back(ent(2'd0, 23'h81, 2'b01, 16'h1313));
            default: ;
         endcase
         @(negedge clk_rom);
         check($sformatf("ovf_flag_%0d", i), overflow, (i >= 4) ? 1 : 0);
      end
      ioctl_wr = 1'b0;
      repeat (4) @(negedge clk_rom);
      check("ovf_one_req_pending", req_cnt - base_req, 1);
      rdy_hold = 1'b0;
      wait_done(base + 4, 1'b0, "ovf");
      repeat (10) @(negedge clk_rom);
      check("ovf_queue_drained", exp_q.size(), 0);
      check("ovf_write_count", req_cnt - base_req, 4);
      check("ovf_sticky", overflow, 1);
      downloading = 1'b0;
      repeat (2) @(negedge clk_rom);
      downloading = 1'b1;
      @(negedge clk_rom);
      #1;
      check("ovf_clear_on_rise", overflow, 0);

      // Full FIFO with a push landing on the pop cycle
      rdy_hold = 1'b1;
      rdy_dly  = 0;
      base     = done_cnt;
      send(25'h000200, 8'h50, ent(2'd0, 23'h100, 2'b10, 16'h5050));
      send(25'h000201, 8'h51, ent(2'd0, 23'h100, 2'b01, 16'h5151));
      send(25'h000202, 8'h52, ent(2'd0, 23'h101, 2'b10, 16'h5252));
      send(25'h000203, 8'h53, ent(2'd0, 23'h101, 2'b01, 16'h5353));
      repeat (3) @(negedge clk_rom);
      check("full_no_ovf", overflow, 0);
      #1;
      rdy_hold = 1'b0;
      send(25'h040007, 8'h54, ent(2'd1, 23'h3, 2'b01, 16'h5454));
      check("full_pop_push_ovf", overflow, 0);
      wait_done(base + 5, 1'b0, "fullpop");
      check("fullpop_ovf_end", overflow, 0);
      rdy_dly = 1;

      // Drain after downloading falls
      ack_dly = 2;
      rdy_dly = 2;
      base    = done_cnt;
      send(25'h080010, 8'h60, ent(2'd2, 23'h8, 2'b10, 16'h6060));
      send(25'h080011, 8'h61, ent(2'd2, 23'h8, 2'b01, 16'h6161));
      send(25'h0C0012, 8'h62, ent(2'd3, 23'h9, 2'b10, 16'h6262));
      downloading = 1'b0;
      wait_done(base + 3, 1'b1, "drain");

      // Reset while a request is pending with two entries queued
      ack_dly     = 1;
      rdy_dly     = 1;
      ack_hold    = 1'b1;
      downloading = 1'b1;
      send(25'h000300, 8'h70, ent(2'd0, 23'h180, 2'b10, 16'h7070));
      send(25'h000301, 8'h71, ent(2'd0, 23'h180, 2'b01, 16'h7171));
      send(25'h000302, 8'h72, ent(2'd0, 23'h181, 2'b10, 16'h7272));
      @(negedge clk_rom);
      check("rst_mid_we_before", prog_we, 1);
      base        = done_cnt;
      base_req    = req_cnt;
      downloading = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_we",   prog_we,    0);
      check("rst_mid_busy", dwnld_busy, 0);
      check("rst_mid_mask", prog_mask,  2'b11);
      abort    = 1'b1;
      ack_hold = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk_rom);
      rst_n = 1'b1;
      repeat (20) @(negedge clk_rom);
      check("rst_mid_no_req",  req_cnt - base_req, 0);
      check("rst_mid_no_done", done_cnt - base, 0);
      check("rst_mid_idle_we", prog_we, 0);
      check("rst_mid_idle_busy", dwnld_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
